// File: rtl/mo_vertical_scanner.sv
// mo_vertical_scanner
// Per-line vertical scan of the motion-object Y table. On each line_start the
// whole table is walked one entry per ce cycle: the address is issued, the
// table returns Y one ce cycle later, and the compare stage checks VC + Y
// against the object height window. Hits are queued as {index, row}, in
// ascending index order, in a small list that the horizontal stage pops.
//
// Pipeline for address a issued on ce cycle k (line_start edge is cycle 0):
//   cycle k      obj_addr = a
//   cycle k+1    table samples a, pend_idx = a
//   cycle k+2    obj_y(a) compared, list written
// The last address is issued on cycle NUM_OBJ-1, so the last compare and the
// done pulse both land on ce cycle NUM_OBJ+1.
//
// state | meaning
// IDLE  | no scan; list holds the results of the last completed scan
// SCAN  | issuing addresses, comparing the entry issued one cycle earlier
// DRAIN | final compare of the last entry, then done pulse

module mo_vertical_scanner #(
  parameter int NUM_OBJ      = 64,
  parameter int VW           = 8,
  parameter int HBITS        = 4,
  parameter int MAX_PER_LINE = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       line_start,
  input  logic [VW-1:0]              VC,
  input  logic                       PLAYER2,
  output logic [$clog2(NUM_OBJ)-1:0] obj_addr,
  input  logic [VW-1:0]              obj_y,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       out_valid,
  output logic [$clog2(NUM_OBJ)-1:0] out_idx,
  output logic [HBITS-1:0]           out_row,
  input  logic                       out_pop
);

  localparam int AW = $clog2(NUM_OBJ);
  localparam int LW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_OBJ - 1);
  localparam logic [LW:0]   LIST_FULL = (LW + 1)'(MAX_PER_LINE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [VW-1:0]   vc_q;
  logic            p2_q;
  logic            pend_valid;
  logic [AW-1:0]   pend_idx;

  logic [AW-1:0]    list_idx [MAX_PER_LINE];
  logic [HBITS-1:0] list_row [MAX_PER_LINE];
  logic [LW-1:0]    rd_ptr;
  logic [LW-1:0]    wr_ptr;
  logic [LW:0]      count;

  logic [VW-1:0]    sum;
  logic             hit;
  logic [HBITS-1:0] row;
  logic             list_full;
  logic             pop_ok;
  logic             push_ok;

  // Carry out of the add is dropped on purpose so objects straddling the
  // wrap point of the vertical counter match on both sides.
  assign sum       = vc_q + obj_y;
  assign hit       = pend_valid && (&sum[VW-1:HBITS]);
  assign row       = sum[HBITS-1:0] ^ {HBITS{p2_q}};
  assign list_full = (count == LIST_FULL);
  assign pop_ok    = out_pop && (count != '0);
  // A pop in the same cycle frees the slot, so a full list still takes the hit.
  assign push_ok   = hit && (!list_full || pop_ok);

  assign busy      = (state != IDLE);
  assign out_valid = (count != '0);
  assign out_idx   = list_idx[rd_ptr];
  assign out_row   = list_row[rd_ptr];

  // Scan sequencer: address generation, compare pipeline tag, done and overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vc_q       <= '0;
      p2_q       <= 1'b0;
      obj_addr   <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      if (line_start) begin
        // Restart (or abort) the scan; any in-flight compare is discarded.
        vc_q       <= VC;
        p2_q       <= PLAYER2;
        obj_addr   <= '0;
        pend_valid <= 1'b0;
        overflow   <= 1'b0;
        state      <= SCAN;
      end else begin
        if (hit && list_full && !pop_ok)
          overflow <= 1'b1;
        case (state)
          IDLE: begin
            pend_valid <= 1'b0;
          end
          SCAN: begin
            pend_valid <= 1'b1;
            pend_idx   <= obj_addr;
            if (obj_addr == LAST_ADDR)
              state <= DRAIN;
            else
              obj_addr <= obj_addr + AW'(1);
          end
          DRAIN: begin
            pend_valid <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
          default: begin
            pend_valid <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

  // Per-line match list: circular buffer written in index order, popped at the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        list_idx[i] <= '0;
        list_row[i] <= '0;
      end
    end else if (ce) begin
      if (line_start) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          list_idx[wr_ptr] <= pend_idx;
          list_row[wr_ptr] <= row;
          wr_ptr           <= wr_ptr + LW'(1);
        end
        if (pop_ok)
          rd_ptr <= rd_ptr + LW'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + (LW + 1)'(1);
          2'b01:   count <= count - (LW + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mo_vertical_scanner.sv
// Bench for mo_vertical_scanner: table of single-object scans plus hand-built
// sequences for overflow, pop-while-scanning, abort, reset and ce stall.
// Expected list entries go into a queue when a scan is launched and are
// popped as the DUT presents its list head.

module tb_mo_vertical_scanner;

  logic       clk = 1'b0;
  logic       reset, ce, line_start, PLAYER2, out_pop;
  logic [7:0] VC, obj_y;
  logic [5:0] obj_addr, out_idx;
  logic [3:0] out_row;
  logic       busy, done, overflow, out_valid;

  logic [7:0] ymem [64];

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [5:0] idx;
    logic [3:0] row;
  } ent_t;
  ent_t exp_q[$];

  typedef struct {
    logic [7:0] vc;
    logic       p2;
    int         obj;
    logic [7:0] y;
    logic       exp_hit;
    logic [3:0] exp_row;
    string      name;
  } vec_t;
  vec_t vecs[8];

  mo_vertical_scanner #(
    .NUM_OBJ(64), .VW(8), .HBITS(4), .MAX_PER_LINE(8)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .line_start(line_start),
    .VC(VC), .PLAYER2(PLAYER2), .obj_addr(obj_addr), .obj_y(obj_y),
    .busy(busy), .done(done), .overflow(overflow), .out_valid(out_valid),
    .out_idx(out_idx), .out_row(out_row), .out_pop(out_pop)
  );

  always #5 clk = ~clk;

  // Object table: registered read, one ce cycle of latency.
  always @(posedge clk) if (ce) obj_y <= ymem[obj_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 64; i++) ymem[i] = 8'h00;
  endtask

  task automatic push_exp(input int idx, input logic [3:0] row);
    ent_t e;
    e.idx = 6'(idx);
    e.row = row;
    exp_q.push_back(e);
  endtask

  // Reference scan: queues up to 'limit' expected entries in index order.
  task automatic model_scan(input logic [7:0] vc, input logic p2, input int limit);
    logic [8:0] wide;
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      wide = {1'b0, vc} + {1'b0, ymem[i]};
      if (wide[7:4] == 4'hF) begin
        if (n < limit) push_exp(i, wide[3:0] ^ {4{p2}});
        n++;
      end
    end
  endtask

  task automatic start_scan(input logic [7:0] vc, input logic p2);
    VC = vc;
    PLAYER2 = p2;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic compare_head(input string nm);
    ent_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: unexpected entry idx %0d row %0h, expected none", nm, out_idx, out_row);
    end else begin
      e = exp_q.pop_front();
      check({nm, " idx"}, 32'(out_idx), 32'(e.idx));
      check({nm, " row"}, 32'(out_row), 32'(e.row));
    end
  endtask

  // Counts ce cycles until done; pops the head every cycle from pop_from on.
  task automatic wait_done(input string nm, input int pop_from, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      out_pop = 1'b0;
      if (i >= pop_from && out_valid) begin
        compare_head(nm);
        out_pop = 1'b1;
      end
      step();
      if (done) begin
        cyc = i;
        break;
      end
    end
    out_pop = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 20; k++) begin
      if (!out_valid) break;
      compare_head(nm);
      out_pop = 1'b1;
      step();
      out_pop = 1'b0;
    end
    check({nm, " entries missing"}, 32'(exp_q.size()), 32'd0);
    check({nm, " out_valid after drain"}, 32'(out_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dones;

    vecs[0] = '{8'h10, 1'b0, 3,  8'hE5, 1'b1, 4'h5, "single"};
    vecs[1] = '{8'h10, 1'b1, 3,  8'hE5, 1'b1, 4'hA, "single_flip"};
    vecs[2] = '{8'h10, 1'b0, 3,  8'hD0, 1'b0, 4'h0, "below_window"};
    vecs[3] = '{8'h10, 1'b1, 3,  8'hD0, 1'b0, 4'h0, "below_window_flip"};
    vecs[4] = '{8'h20, 1'b0, 63, 8'hD8, 1'b1, 4'h8, "last_object"};
    vecs[5] = '{8'h0A, 1'b0, 0,  8'hF5, 1'b1, 4'hF, "window_top"};
    vecs[6] = '{8'h0B, 1'b0, 0,  8'hF5, 1'b0, 4'h0, "wrap_carry_dropped"};
    vecs[7] = '{8'h0A, 1'b1, 63, 8'hE6, 1'b1, 4'hF, "window_bottom_flip"};

    reset = 1'b1; ce = 1'b1; line_start = 1'b0; out_pop = 1'b0;
    VC = 8'h00; PLAYER2 = 1'b0;
    clear_table();
    step(); step(); step();
    reset = 1'b0;
    step();
    check("reset busy",      32'(busy),      32'd0);
    check("reset done",      32'(done),      32'd0);
    check("reset overflow",  32'(overflow),  32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset obj_addr",  32'(obj_addr),  32'd0);
    check("reset out_idx",   32'(out_idx),   32'd0);
    check("reset out_row",   32'(out_row),   32'd0);

    // Single-object table vectors.
    foreach (vecs[v]) begin
      clear_table();
      ymem[vecs[v].obj] = vecs[v].y;
      if (vecs[v].exp_hit) push_exp(vecs[v].obj, vecs[v].exp_row);
      start_scan(vecs[v].vc, vecs[v].p2);
      check({vecs[v].name, " busy"}, 32'(busy), 32'd1);
      wait_done(vecs[v].name, 1000, cyc);
      check({vecs[v].name, " done cycle"}, 32'(cyc), 32'd65);
      check({vecs[v].name, " busy at done"}, 32'(busy), 32'd0);
      check({vecs[v].name, " overflow"}, 32'(overflow), 32'd0);
      check({vecs[v].name, " out_valid"}, 32'(out_valid), 32'(vecs[v].exp_hit));
      step();
      check({vecs[v].name, " done one cycle"}, 32'(done), 32'd0);
      drain(vecs[v].name);
    end

    // Overflow: ten hits, only the first eight kept.
    clear_table();
    for (int i = 0; i < 10; i++) ymem[i] = 8'hEF;
    model_scan(8'h10, 1'b0, 8);
    start_scan(8'h10, 1'b0);
    wait_done("overflow", 1000, cyc);
    check("overflow done cycle", 32'(cyc), 32'd65);
    check("overflow flag", 32'(overflow), 32'd1);
    check("overflow head idx", 32'(out_idx), 32'd0);
    check("overflow head row", 32'(out_row), 32'hF);
    drain("overflow");
    check("overflow sticky", 32'(overflow), 32'd1);

    // Concurrent pop from the first cycle, twelve spaced hits.
    clear_table();
    for (int i = 0; i < 12; i++) ymem[i * 5 + 2] = 8'hE0 + 8'(i);
    model_scan(8'h10, 1'b0, 64);
    start_scan(8'h10, 1'b0);
    check("new line clears overflow", 32'(overflow), 32'd0);
    wait_done("live_pop", 1, cyc);
    check("live_pop done cycle", 32'(cyc), 32'd65);
    check("live_pop overflow", 32'(overflow), 32'd0);
    drain("live_pop");

    // Twelve back-to-back hits; popping starts once the list is full.
    clear_table();
    for (int i = 0; i < 12; i++) ymem[i] = 8'hE0 + 8'(i);
    model_scan(8'h10, 1'b1, 64);
    start_scan(8'h10, 1'b1);
    wait_done("full_pop", 10, cyc);
    check("full_pop done cycle", 32'(cyc), 32'd65);
    check("full_pop overflow", 32'(overflow), 32'd0);
    drain("full_pop");

    // Abort: restart at ce cycle 20 with a different VC.
    clear_table();
    ymem[2]  = 8'hE0;
    ymem[40] = 8'hD3;
    start_scan(8'h10, 1'b0);
    dones = 0;
    for (int i = 1; i < 20; i++) begin
      step();
      if (done) dones++;
    end
    check("abort first scan has entry", 32'(out_valid), 32'd1);
    push_exp(40, 4'h3);
    start_scan(8'h20, 1'b0);
    check("abort list cleared", 32'(out_valid), 32'd0);
    wait_done("abort", 1000, cyc);
    check("abort early dones", 32'(dones), 32'd0);
    check("abort done cycle", 32'(cyc), 32'd65);
    drain("abort");

    // Reset mid-scan, with a simultaneous line_start.
    start_scan(8'h10, 1'b0);
    for (int i = 1; i <= 10; i++) step();
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    line_start = 1'b1;
    step();
    reset = 1'b0;
    line_start = 1'b0;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset obj_addr", 32'(obj_addr), 32'd0);
    check("midreset overflow", 32'(overflow), 32'd0);
    step(); step();
    check("midreset stays idle", 32'(busy), 32'd0);

    // ce stall mid-scan, and done held across a ce gap.
    start_scan(8'h10, 1'b0);
    for (int i = 1; i <= 30; i++) step();
    check("stall obj_addr before", 32'(obj_addr), 32'd30);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("stall obj_addr", 32'(obj_addr), 32'd30);
    check("stall busy", 32'(busy), 32'd1);
    check("stall out_valid", 32'(out_valid), 32'd1);
    check("stall out_idx", 32'(out_idx), 32'd2);
    check("stall out_row", 32'(out_row), 32'd0);
    ce = 1'b1;
    wait_done("stall", 1000, cyc);
    check("stall done cycle", 32'(cyc), 32'd35);
    ce = 1'b0;
    step(); step();
    check("done held while ce low", 32'(done), 32'd1);
    ce = 1'b1;
    step();
    check("done clears on next ce", 32'(done), 32'd0);
    push_exp(2, 4'h0);
    drain("stall");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
